// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between a fetch and a data
// requester with round-robin grant, misalign reject and fixed latency.
// Ports: clock/reset, if_* fetch side, d_* data side, mem_* shared
// port, gnt_if/gnt_d current owner, busy port occupied.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int MEM_LAT = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [1:0]  d_size,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic [63:0] d_rdata,
  output logic        d_done,
  output logic        d_misalign,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [1:0]  mem_size,
  output logic        mem_wr,
  input  logic [63:0] mem_rdata,
  output logic        gnt_if,
  output logic        gnt_d,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, READ, WRITE, RESP, MISAL
  } state_t;

  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic        r_own_d;
  logic        r_wr;
  logic        r_last_if;
  logic        r_if_done;
  logic        r_d_done;
  logic        r_d_mis;
  logic [31:0] r_if_rdata;
  logic [63:0] r_d_rdata;
  logic [63:0] r_mem_addr;
  logic [63:0] r_mem_wdata;
  logic [1:0]  r_mem_size;
  logic        r_mem_wr;
  logic        r_gnt_if;
  logic        r_gnt_d;

  logic w_if_ok;
  logic w_d_ok;
  logic w_pick_d;
  logic w_pick_if;
  logic w_mis;

  // A requester whose done is pulsing this cycle has not yet seen it,
  // so its still-high req is not a new request until the next cycle.
  assign w_if_ok   = if_req & ~r_if_done;
  assign w_d_ok    = d_req & ~r_d_done;
  assign w_pick_d  = w_d_ok & (~w_if_ok | r_last_if);
  assign w_pick_if = w_if_ok & ~w_pick_d;

  always_comb begin
    w_mis = 1'b0;
    unique case (d_size)
      2'd0: w_mis = 1'b0;
      2'd1: w_mis = d_addr[0];
      2'd2: w_mis = |d_addr[1:0];
      2'd3: w_mis = |d_addr[2:0];
      default: w_mis = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_own_d     <= 1'b0;
      r_wr        <= 1'b0;
      r_last_if   <= 1'b1;
      r_if_done   <= 1'b0;
      r_d_done    <= 1'b0;
      r_d_mis     <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_size  <= '0;
      r_mem_wr    <= 1'b0;
      r_gnt_if    <= 1'b0;
      r_gnt_d     <= 1'b0;
    end else begin
      r_if_done <= 1'b0;
      r_d_done  <= 1'b0;
      r_d_mis   <= 1'b0;
      r_mem_wr  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_gnt_if <= w_pick_if;
          r_gnt_d  <= w_pick_d;
          if (w_pick_d) begin
            r_last_if <= 1'b0;
            r_own_d   <= 1'b1;
            r_wr      <= d_wr;
            if (w_mis) begin
              r_state <= MISAL;
            end else begin
              r_mem_addr  <= d_addr;
              r_mem_size  <= d_size;
              r_mem_wdata <= d_wdata;
              if (d_wr) begin
                r_mem_wr <= 1'b1;
                r_state  <= WRITE;
              end else begin
                r_cnt   <= LAT_M1;
                r_state <= READ;
              end
            end
          end else if (w_pick_if) begin
            r_last_if  <= 1'b1;
            r_own_d    <= 1'b0;
            r_wr       <= 1'b0;
            r_mem_addr <= if_addr;
            r_mem_size <= 2'd2;
            r_cnt      <= LAT_M1;
            r_state    <= READ;
          end
        end
        READ: begin
          if (r_cnt == 3'd0) r_state <= RESP;
          else r_cnt <= r_cnt - 3'd1;
        end
        WRITE: r_state <= RESP;
        RESP: begin
          r_state <= IDLE;
          if (r_own_d) begin
            r_d_done <= 1'b1;
            if (!r_wr) r_d_rdata <= mem_rdata;
          end else begin
            r_if_done  <= 1'b1;
            r_if_rdata <= mem_rdata[31:0];
          end
        end
        MISAL: begin
          r_state  <= IDLE;
          r_d_done <= 1'b1;
          r_d_mis  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign if_rdata   = r_if_rdata;
  assign if_done    = r_if_done;
  assign d_rdata    = r_d_rdata;
  assign d_done     = r_d_done;
  assign d_misalign = r_d_mis;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_size   = r_mem_size;
  assign mem_wr     = r_mem_wr;
  assign gnt_if     = r_gnt_if;
  assign gnt_d      = r_gnt_d;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with
// directed scenarios, random traffic and MEM_LAT 1/2/7 instances.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int L = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tot = 0;
  int n_bad = 0;
  int n_wr  = 0;
  bit saw_gnt_d = 1'b0;

  logic        if_req = 0;
  logic [63:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_req = 0;
  logic        d_wr = 0;
  logic [1:0]  d_size = '0;
  logic [63:0] d_addr = '0;
  logic [63:0] d_wdata = '0;
  logic [63:0] d_rdata;
  logic        d_done;
  logic        d_misalign;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [1:0]  mem_size;
  logic        mem_wr;
  logic [63:0] mem_rdata;
  logic        gnt_if;
  logic        gnt_d;
  logic        busy;

  function automatic logic [63:0] fmem(input logic [63:0] a);
    if (a == 64'h40) return 64'h00A00093;
    return {a[31:0] ^ 32'h5A5A1234, ~a[31:0]};
  endfunction

  assign mem_rdata = fmem(mem_addr);

  mem_port_arbiter #(.MEM_LAT(L)) u_dut (
    .clock(clk), .reset(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .d_misalign(d_misalign),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata),
    .gnt_if(gnt_if), .gnt_d(gnt_d), .busy(busy)
  );

  // fetch-only instances for MEM_LAT 1 and 7
  logic        x_req[2];
  logic [63:0] x_addr[2];
  logic [31:0] x_ifr[2];
  logic        x_ifd[2];
  logic [63:0] x_dr[2];
  logic        x_dd[2];
  logic        x_mis[2];
  logic [63:0] x_ma[2];
  logic [63:0] x_mw[2];
  logic [1:0]  x_ms[2];
  logic        x_mwr[2];
  logic [63:0] x_mr[2];
  logic        x_gi[2];
  logic        x_gd[2];
  logic        x_bz[2];

  assign x_mr[0] = fmem(x_ma[0]);
  assign x_mr[1] = fmem(x_ma[1]);

  mem_port_arbiter #(.MEM_LAT(1)) u_l1 (
    .clock(clk), .reset(rst),
    .if_req(x_req[0]), .if_addr(x_addr[0]),
    .if_rdata(x_ifr[0]), .if_done(x_ifd[0]),
    .d_req(1'b0), .d_wr(1'b0), .d_size(2'd0),
    .d_addr(64'd0), .d_wdata(64'd0),
    .d_rdata(x_dr[0]), .d_done(x_dd[0]),
    .d_misalign(x_mis[0]),
    .mem_addr(x_ma[0]), .mem_wdata(x_mw[0]),
    .mem_size(x_ms[0]), .mem_wr(x_mwr[0]),
    .mem_rdata(x_mr[0]),
    .gnt_if(x_gi[0]), .gnt_d(x_gd[0]), .busy(x_bz[0])
  );

  mem_port_arbiter #(.MEM_LAT(7)) u_l7 (
    .clock(clk), .reset(rst),
    .if_req(x_req[1]), .if_addr(x_addr[1]),
    .if_rdata(x_ifr[1]), .if_done(x_ifd[1]),
    .d_req(1'b0), .d_wr(1'b0), .d_size(2'd0),
    .d_addr(64'd0), .d_wdata(64'd0),
    .d_rdata(x_dr[1]), .d_done(x_dd[1]),
    .d_misalign(x_mis[1]),
    .mem_addr(x_ma[1]), .mem_wdata(x_mw[1]),
    .mem_size(x_ms[1]), .mem_wr(x_mwr[1]),
    .mem_rdata(x_mr[1]),
    .gnt_if(x_gi[1]), .gnt_d(x_gd[1]), .busy(x_bz[1])
  );

  typedef struct {
    logic [63:0] data;
    logic        mis;
    int          cyc;
    logic [63:0] maddr;
    logic [1:0]  msize;
  } exp_t;

  typedef struct {
    logic [63:0] a;
    logic [63:0] w;
    logic [1:0]  s;
  } st_t;

  exp_t q_if[$];
  exp_t q_d[$];
  st_t  q_st[$];

  // reference model of architecturally visible state
  logic [63:0] m_drdata = '0;
  logic [63:0] m_maddr  = '0;
  logic [1:0]  m_msize  = '0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    n_tot++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h cyc=%0d", nm, got, want, cyc);
    end
  endtask

  // monitor: pops expectations whenever the DUT presents a result
  always @(negedge clk) begin
    exp_t e;
    st_t  s;
    if (gnt_d) saw_gnt_d = 1'b1;
    chk("gnt_onehot", 64'(gnt_if & gnt_d), 64'd0);
    if (if_done) begin
      if (q_if.size() == 0) chk("if_done_unexp", 64'd1, 64'd0);
      else begin
        e = q_if.pop_front();
        chk("if_cyc", 64'(cyc), 64'(e.cyc));
        chk("if_rdata", 64'(if_rdata), e.data);
        chk("if_maddr", mem_addr, e.maddr);
        chk("if_msize", 64'(mem_size), 64'(e.msize));
      end
    end
    if (d_done) begin
      if (q_d.size() == 0) chk("d_done_unexp", 64'd1, 64'd0);
      else begin
        e = q_d.pop_front();
        chk("d_cyc", 64'(cyc), 64'(e.cyc));
        chk("d_rdata", d_rdata, e.data);
        chk("d_mis", 64'(d_misalign), 64'(e.mis));
        chk("d_maddr", mem_addr, e.maddr);
        chk("d_msize", 64'(mem_size), 64'(e.msize));
      end
    end
    if (d_misalign && !d_done) chk("mis_alone", 64'd1, 64'd0);
    if (mem_wr) begin
      n_wr++;
      if (q_st.size() == 0) chk("wr_unexp", 64'd1, 64'd0);
      else begin
        s = q_st.pop_front();
        chk("wr_addr", mem_addr, s.a);
        chk("wr_data", mem_wdata, s.w);
        chk("wr_size", 64'(mem_size), 64'(s.s));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_if(input logic [63:0] a, input int dly);
    exp_t e;
    logic [63:0] v;
    v = fmem(a);
    m_maddr = a;
    m_msize = 2'd2;
    e.data  = {32'd0, v[31:0]};
    e.mis   = 1'b0;
    e.cyc   = cyc + dly + L + 2;
    e.maddr = m_maddr;
    e.msize = m_msize;
    q_if.push_back(e);
    if_addr = a;
    if_req  = 1'b1;
  endtask

  task automatic issue_d(input logic wr, input logic [1:0] sz,
                         input logic [63:0] a,
                         input logic [63:0] w, input int dly);
    exp_t e;
    st_t  s;
    logic [63:0] nb;
    bit   mis;
    nb  = 64'd1 << sz;
    mis = (a % nb) != 0;
    e.mis = mis;
    if (mis) begin
      e.cyc = cyc + dly + 2;
    end else if (wr) begin
      e.cyc = cyc + dly + 3;
      m_maddr = a;
      m_msize = sz;
      s.a = a;
      s.w = w;
      s.s = sz;
      q_st.push_back(s);
    end else begin
      e.cyc = cyc + dly + L + 2;
      m_drdata = fmem(a);
      m_maddr = a;
      m_msize = sz;
    end
    e.data  = m_drdata;
    e.maddr = m_maddr;
    e.msize = m_msize;
    q_d.push_back(e);
    d_wr    = wr;
    d_size  = sz;
    d_addr  = a;
    d_wdata = w;
    d_req   = 1'b1;
  endtask

  task automatic wait_done(input bit dsel);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = dsel ? d_done : if_done;
    end
    if (!got) chk(dsel ? "d_timeout" : "if_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_reset(input string tag);
    @(negedge clk);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_gnt"}, 64'({gnt_if, gnt_d}), 64'd0);
    chk({tag, "_done"}, 64'({if_done, d_done, d_misalign}), 64'd0);
    chk({tag, "_mem_wr"}, 64'(mem_wr), 64'd0);
    chk({tag, "_mem_addr"}, mem_addr, 64'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 64'd0);
    chk({tag, "_mem_size"}, 64'(mem_size), 64'd0);
    chk({tag, "_if_rdata"}, 64'(if_rdata), 64'd0);
    chk({tag, "_d_rdata"}, d_rdata, 64'd0);
  endtask

  task automatic b2b(input int k, input int lat);
    logic [63:0] a;
    logic [63:0] fw;
    int last;
    int t0;
    bit got;
    last = 0;
    a = 64'h1000 + 64'(k) * 64'h100;
    x_addr[k] = a;
    x_req[k]  = 1'b1;
    t0 = cyc;
    for (int n = 0; n < 3; n++) begin
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clk);
        got = x_ifd[k];
      end
      if (!got) begin
        chk("b2b_timeout", 64'd0, 64'd1);
        break;
      end
      fw = fmem(a);
      chk("b2b_data", 64'(x_ifr[k]), {32'd0, fw[31:0]});
      if (n == 0) chk("b2b_first", 64'(cyc - t0), 64'(lat + 2));
      else chk("b2b_space", 64'(cyc - last), 64'(lat + 3));
      last = cyc;
      tick();
      a = a + 64'd4;
      x_addr[k] = a;
    end
    x_req[k] = 1'b0;
  endtask

  initial begin
    int snap;
    int prev;
    int kind;
    logic [63:0] ra;
    for (int k = 0; k < 2; k++) begin
      x_req[k]  = 1'b0;
      x_addr[k] = '0;
    end
    repeat (3) tick();
    check_reset("por");
    tick();
    rst = 1'b0;

    // both requests after reset: data first, fetch next
    issue_d(1'b0, 2'd3, 64'h208, 64'd0, 0);
    issue_if(64'h80, L + 2);
    wait_done(1'b1);
    tick();
    d_req = 1'b0;
    wait_done(1'b0);
    tick();
    if_req = 1'b0;
    tick();

    // single fetch of a known word
    saw_gnt_d = 1'b0;
    issue_if(64'h40, 0);
    wait_done(1'b0);
    chk("fetch_word", 64'(if_rdata), 64'h00A00093);
    tick();
    if_req = 1'b0;
    chk("fetch_no_gnt_d", 64'(saw_gnt_d), 64'd0);
    tick();

    // load to give d_rdata a value, then a dword store
    issue_d(1'b0, 2'd3, 64'h200, 64'd0, 0);
    wait_done(1'b1);
    tick();
    d_req = 1'b0;
    tick();
    snap = n_wr;
    issue_d(1'b1, 2'd3, 64'h100, 64'hDEADBEEF, 0);
    wait_done(1'b1);
    chk("st_rdata_kept", d_rdata, fmem(64'h200));
    tick();
    d_req = 1'b0;
    chk("st_wr_cycles", 64'(n_wr - snap), 64'd1);
    tick();

    // misaligned word load
    snap = n_wr;
    issue_d(1'b0, 2'd2, 64'h102, 64'd0, 0);
    wait_done(1'b1);
    chk("mis_flag", 64'(d_misalign), 64'd1);
    chk("mis_maddr", mem_addr, 64'h100);
    tick();
    d_req = 1'b0;
    chk("mis_no_wr", 64'(n_wr - snap), 64'd0);
    tick();

    // data was served last: fetch wins the tie
    issue_if(64'hC0, 0);
    issue_d(1'b0, 2'd2, 64'h310, 64'd0, L + 2);
    wait_done(1'b0);
    tick();
    if_req = 1'b0;
    wait_done(1'b1);
    tick();
    d_req = 1'b0;
    tick();

    // randomized traffic, one requester at a time
    prev = -1;
    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(1, 0));
      ra = {$urandom, $urandom};
      if (!(kind == prev && $urandom_range(1, 0) == 1)) begin
        if_req = 1'b0;
        d_req  = 1'b0;
        repeat ($urandom_range(2, 0)) tick();
      end
      if (kind == 0) begin
        issue_if({ra[63:2], 2'b00}, 0);
      end else begin
        issue_d(1'($urandom_range(1, 0)),
                2'($urandom_range(3, 0)), ra,
                {$urandom, $urandom}, 0);
      end
      wait_done(kind == 1);
      tick();
      prev = kind;
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    tick();
    tick();

    // reset during the first READ cycle aborts the fetch
    if_addr = 64'h300;
    if_req  = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if_req = 1'b0;
    m_drdata = '0;
    m_maddr  = '0;
    m_msize  = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_no_done", 64'({if_done, d_done}), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
    end
    check_reset("mid");
    tick();

    b2b(0, 1);
    b2b(1, 7);
    tick();

    chk("q_if_left", 64'(q_if.size()), 64'd0);
    chk("q_d_left", 64'(q_d.size()), 64'd0);
    chk("q_st_left", 64'(q_st.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
